pipe_hazard_ctrl: RTL and testbench
===================================

PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 The block SHALL have parameter FORWARD_EN, default 1, meaning 1 = EXE/MEM forwarding present, so only load-use stalls; 0 = every RAW hazard against EXE or MEM stalls.
REQ-002 The block SHALL have parameter BR_FLUSH_CYCLES, default 2, legal 1..4, meaning total cycles of flush per taken branch, including the detection cycle.
REQ-003 The block SHALL have one clock and a synchronous, active-high reset.
REQ-004 Port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 Port rst, input, 1 bit: synchronous, active-high reset.
REQ-006 Port id_src1, input, 4 bits: first source register of the instruction in ID.
REQ-007 Port id_src2, input, 4 bits: second source register of the instruction in ID.
REQ-008 Port id_two_src, input, 1 bit: 1 = id_src2 is a real operand.
REQ-009 Port exe_dest, input, 4 bits: destination register held in ID/EXE.
REQ-010 Port exe_wb_en, input, 1 bit: write-back enable held in ID/EXE.
REQ-011 Port exe_mem_read, input, 1 bit: load indication held in ID/EXE.
REQ-012 Port mem_dest, input, 4 bits: destination register held in EXE/MEM.
REQ-013 Port mem_wb_en, input, 1 bit: write-back enable held in EXE/MEM.
REQ-014 Port br_taken, input, 1 bit: taken branch resolved in EXE this cycle.
REQ-015 Port mem_busy, input, 1 bit: data memory not ready; the pipeline must hold.
REQ-016 Port pc_freeze, output, 1 bit: hold the PC.
REQ-017 Port if_id_freeze, output, 1 bit: hold IF/ID.
REQ-018 Port if_id_flush, output, 1 bit: clear IF/ID to a bubble.
REQ-019 Port id_exe_freeze, output, 1 bit: hold ID/EXE.
REQ-020 Port id_exe_flush, output, 1 bit: load a bubble into ID/EXE (wb_en, mem_read, mem_write and br all 0).
REQ-021 Port stall_cnt, output, 16 bits: saturating count of cycles with pc_freeze=1.
REQ-022 Port flush_cnt, output, 16 bits: saturating count of serviced taken branches.

Function
REQ-023 The block SHALL implement states RUN, BR_FLUSH and MEM_HOLD, plus a 2-bit flush counter fcnt and a 1-bit pending-branch flag br_pend.
REQ-024 The hazard term SHALL be src_hit(d, en) = en AND (d==id_src1 OR (id_two_src AND d==id_src2)).
REQ-025 The hazard term SHALL be computed combinationally as follows:
- FORWARD_EN=1: hazard = src_hit(exe_dest, exe_wb_en AND exe_mem_read).
- FORWARD_EN=0: hazard = src_hit(exe_dest, exe_wb_en) OR src_hit(mem_dest, mem_wb_en).
REQ-026 In RUN, priority SHALL be mem_busy, then br_taken or br_pend, then hazard, then idle.
REQ-027 RUN with mem_busy=1: pc_freeze, if_id_freeze and id_exe_freeze SHALL all be 1 and both flushes 0; next state is MEM_HOLD; if br_taken=1, br_pend is set to 1.
REQ-028 RUN with (br_taken OR br_pend) and mem_busy=0: if_id_flush=1, id_exe_flush=1 and no freeze this cycle.
- br_pend is cleared and flush_cnt increments.
- If BR_FLUSH_CYCLES>1: next state is BR_FLUSH with fcnt=BR_FLUSH_CYCLES-2.
- Otherwise the state stays RUN.
REQ-029 RUN with hazard only: pc_freeze=1, if_id_freeze=1, id_exe_flush=1 (bubble insertion) and id_exe_freeze=0; the state stays RUN and re-evaluates the hazard next cycle.
REQ-030 RUN idle: all five control outputs SHALL be 0.
REQ-031 BR_FLUSH: if_id_flush=1 and id_exe_flush=1; hazard is ignored.
- fcnt==0: next state is RUN.
- Otherwise fcnt decrements.
- A br_taken=1 in BR_FLUSH is ignored, because the wrong-path instruction is being flushed.
REQ-032 BR_FLUSH with mem_busy=1: all freezes SHALL be 1 and all flushes 0; fcnt is held and the state stays BR_FLUSH until mem_busy=0.
REQ-033 MEM_HOLD: all freezes SHALL be 1 and all flushes 0 while mem_busy=1.
- On the first cycle with mem_busy=0, outputs are evaluated exactly as in RUN that same cycle, and the next state follows the RUN rules.
- br_taken=1 seen in MEM_HOLD sets br_pend.
REQ-034 stall_cnt SHALL increment on each cycle with pc_freeze=1, saturating at 16'hFFFF.
REQ-035 flush_cnt SHALL increment once per branch serviced per REQ-028, saturating at 16'hFFFF.
REQ-036 A flush and a freeze of the same register SHALL never be asserted in the same cycle.
REQ-037 All five control outputs SHALL be combinational from state, br_pend and inputs, with zero-cycle latency; stall_cnt and flush_cnt are registered.

Reset
REQ-038 On rst=1 at a rising clk, the block SHALL set state=RUN, fcnt=0, br_pend=0, stall_cnt=0 and flush_cnt=0.
REQ-039 While rst=1, all five control outputs SHALL be 0, and reset SHALL take precedence over any in-progress flush or hold.
REQ-040 Reset asserted mid-BR_FLUSH or mid-MEM_HOLD SHALL leave the block in RUN with no residual pending branch.

Verification
REQ-041 Load-use, FORWARD_EN=1: exe_mem_read=1, exe_wb_en=1, exe_dest=3, id_src1=3 for 1 cycle -> pc_freeze=1, if_id_freeze=1, id_exe_flush=1 for exactly 1 cycle; stall_cnt=1.
REQ-042 No stall with forwarding: exe_wb_en=1, exe_mem_read=0, exe_dest=5, id_src2=5, id_two_src=1 -> no freeze with FORWARD_EN=1; 1 stall cycle with FORWARD_EN=0.
REQ-043 Branch, BR_FLUSH_CYCLES=2: br_taken pulse -> if_id_flush=1 and id_exe_flush=1 for exactly 2 consecutive cycles; flush_cnt=1.
REQ-044 Branch during memory hold: mem_busy=1 for 3 cycles with br_taken=1 in the first cycle -> 3 cycles of all freezes; then a 2-cycle flush begins the cycle mem_busy falls; flush_cnt=1; stall_cnt=3.
REQ-045 Saturation and reset: force 70000 freeze cycles -> stall_cnt=16'hFFFF; then assert rst during BR_FLUSH -> next cycle state=RUN, outputs 0, both counters 0.

Source files
------------

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: load-use / RAW stalls, taken-branch flush sequencing,
// memory-busy holds, and saturating stall/flush event counters.
module pipe_hazard_ctrl #(
    parameter int FORWARD_EN      = 1,
    parameter int BR_FLUSH_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  id_src1,
    input  logic [3:0]  id_src2,
    input  logic        id_two_src,
    input  logic [3:0]  exe_dest,
    input  logic        exe_wb_en,
    input  logic        exe_mem_read,
    input  logic [3:0]  mem_dest,
    input  logic        mem_wb_en,
    input  logic        br_taken,
    input  logic        mem_busy,
    output logic        pc_freeze,
    output logic        if_id_freeze,
    output logic        if_id_flush,
    output logic        id_exe_freeze,
    output logic        id_exe_flush,
    output logic [15:0] stall_cnt,
    output logic [15:0] flush_cnt
);

    typedef enum logic [1:0] {RUN, BR_FLUSH, MEM_HOLD} state_t;

    // Cycles left in BR_FLUSH after the detection cycle, counted down to zero.
    localparam logic [1:0] FCNT_INIT = (BR_FLUSH_CYCLES > 1) ? 2'(BR_FLUSH_CYCLES - 2) : 2'd0;

    state_t      state_q, state_d;
    logic [1:0]  fcnt_q, fcnt_d;
    logic        br_pend_q, br_pend_d;
    logic [15:0] stall_cnt_q, stall_cnt_d;
    logic [15:0] flush_cnt_q, flush_cnt_d;

    logic        hazard;
    logic        pc_frz_c, ifid_frz_c, ifid_fl_c, idexe_frz_c, idexe_fl_c;
    logic        flush_svc;

    function automatic logic src_hit(input logic [3:0] d, input logic en,
                                     input logic [3:0] s1, input logic [3:0] s2,
                                     input logic two);
        return en && ((d == s1) || (two && (d == s2)));
    endfunction

    always_comb begin
        if (FORWARD_EN != 0)
            hazard = src_hit(exe_dest, exe_wb_en && exe_mem_read, id_src1, id_src2, id_two_src);
        else
            hazard = src_hit(exe_dest, exe_wb_en, id_src1, id_src2, id_two_src)
                   || src_hit(mem_dest, mem_wb_en, id_src1, id_src2, id_two_src);
    end

    always_comb begin
        state_d     = state_q;
        fcnt_d      = fcnt_q;
        br_pend_d   = br_pend_q;
        pc_frz_c    = 1'b0;
        ifid_frz_c  = 1'b0;
        ifid_fl_c   = 1'b0;
        idexe_frz_c = 1'b0;
        idexe_fl_c  = 1'b0;
        flush_svc   = 1'b0;
        case (state_q)
            BR_FLUSH: begin
                // A new br_taken here comes from the wrong path and is dropped.
                if (mem_busy) begin
                    pc_frz_c    = 1'b1;
                    ifid_frz_c  = 1'b1;
                    idexe_frz_c = 1'b1;
                end else begin
                    ifid_fl_c  = 1'b1;
                    idexe_fl_c = 1'b1;
                    if (fcnt_q == 2'd0) state_d = RUN;
                    else                fcnt_d  = fcnt_q - 2'd1;
                end
            end
            default: begin
                // RUN, and MEM_HOLD once memory is ready, share the same rules.
                if (mem_busy) begin
                    pc_frz_c    = 1'b1;
                    ifid_frz_c  = 1'b1;
                    idexe_frz_c = 1'b1;
                    state_d     = MEM_HOLD;
                    if (br_taken) br_pend_d = 1'b1;
                end else if (br_taken || br_pend_q) begin
                    ifid_fl_c  = 1'b1;
                    idexe_fl_c = 1'b1;
                    br_pend_d  = 1'b0;
                    flush_svc  = 1'b1;
                    if (BR_FLUSH_CYCLES > 1) begin
                        state_d = BR_FLUSH;
                        fcnt_d  = FCNT_INIT;
                    end else begin
                        state_d = RUN;
                    end
                end else if (hazard) begin
                    pc_frz_c   = 1'b1;
                    ifid_frz_c = 1'b1;
                    idexe_fl_c = 1'b1;
                    state_d    = RUN;
                end else begin
                    state_d = RUN;
                end
            end
        endcase
    end

    assign pc_freeze     = pc_frz_c    && !rst;
    assign if_id_freeze  = ifid_frz_c  && !rst;
    assign if_id_flush   = ifid_fl_c   && !rst;
    assign id_exe_freeze = idexe_frz_c && !rst;
    assign id_exe_flush  = idexe_fl_c  && !rst;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (pc_freeze && (stall_cnt_q != 16'hFFFF)) stall_cnt_d = stall_cnt_q + 16'd1;
        if (flush_svc && (flush_cnt_q != 16'hFFFF)) flush_cnt_d = flush_cnt_q + 16'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= RUN;
            fcnt_q      <= 2'd0;
            br_pend_q   <= 1'b0;
            stall_cnt_q <= 16'd0;
            flush_cnt_q <= 16'd0;
        end else begin
            state_q     <= state_d;
            fcnt_q      <= fcnt_d;
            br_pend_q   <= br_pend_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: instance A uses defaults (forwarding, 2-cycle flush),
// instance B has no forwarding and a 3-cycle flush; both share the same stimulus.
module tb_pipe_hazard_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  id_src1, id_src2, exe_dest, mem_dest;
    logic        id_two_src, exe_wb_en, exe_mem_read, mem_wb_en, br_taken, mem_busy;

    logic        a_pc, a_ifz, a_iff, a_idz, a_idf;
    logic        b_pc, b_ifz, b_iff, b_idz, b_idf;
    logic [15:0] a_stall, a_flush, b_stall, b_flush;
    logic [4:0]  ctl_a, ctl_b;

    int tests = 0;
    int fails = 0;

    // Control vector order: {pc_freeze, if_id_freeze, if_id_flush, id_exe_freeze, id_exe_flush}
    localparam logic [4:0] IDLE  = 5'b00000;
    localparam logic [4:0] STALL = 5'b11001;
    localparam logic [4:0] FLUSH = 5'b00101;
    localparam logic [4:0] HOLD  = 5'b11010;

    assign ctl_a = {a_pc, a_ifz, a_iff, a_idz, a_idf};
    assign ctl_b = {b_pc, b_ifz, b_iff, b_idz, b_idf};

    always #5 clk = ~clk;

    pipe_hazard_ctrl u_dut_a (
        .clk(clk), .rst(rst), .id_src1(id_src1), .id_src2(id_src2), .id_two_src(id_two_src),
        .exe_dest(exe_dest), .exe_wb_en(exe_wb_en), .exe_mem_read(exe_mem_read),
        .mem_dest(mem_dest), .mem_wb_en(mem_wb_en), .br_taken(br_taken), .mem_busy(mem_busy),
        .pc_freeze(a_pc), .if_id_freeze(a_ifz), .if_id_flush(a_iff),
        .id_exe_freeze(a_idz), .id_exe_flush(a_idf), .stall_cnt(a_stall), .flush_cnt(a_flush)
    );

    pipe_hazard_ctrl #(.FORWARD_EN(0), .BR_FLUSH_CYCLES(3)) u_dut_b (
        .clk(clk), .rst(rst), .id_src1(id_src1), .id_src2(id_src2), .id_two_src(id_two_src),
        .exe_dest(exe_dest), .exe_wb_en(exe_wb_en), .exe_mem_read(exe_mem_read),
        .mem_dest(mem_dest), .mem_wb_en(mem_wb_en), .br_taken(br_taken), .mem_busy(mem_busy),
        .pc_freeze(b_pc), .if_id_freeze(b_ifz), .if_id_flush(b_iff),
        .id_exe_freeze(b_idz), .id_exe_flush(b_idf), .stall_cnt(b_stall), .flush_cnt(b_flush)
    );

    // Advance one clock; inputs change 1 time unit after the edge, outputs are read later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_in();
        id_src1 = 4'd0; id_src2 = 4'd0; id_two_src = 1'b0;
        exe_dest = 4'd15; exe_wb_en = 1'b0; exe_mem_read = 1'b0;
        mem_dest = 4'd15; mem_wb_en = 1'b0; br_taken = 1'b0; mem_busy = 1'b0;
    endtask

    task automatic test_reset();
        clear_in();
        rst = 1'b1;
        br_taken = 1'b1; mem_busy = 1'b1;
        exe_dest = 4'd0; exe_wb_en = 1'b1; exe_mem_read = 1'b1;
        step(); step();
        #1;
        tests++;
        if (ctl_a !== IDLE || ctl_b !== IDLE) begin
            fails++; $display("FAIL reset_ctl: a=%b b=%b expected %b", ctl_a, ctl_b, IDLE);
        end
        tests++;
        if (a_stall !== 16'd0 || a_flush !== 16'd0 || b_stall !== 16'd0 || b_flush !== 16'd0) begin
            fails++; $display("FAIL reset_cnt: a=%0d/%0d b=%0d/%0d expected 0", a_stall, a_flush, b_stall, b_flush);
        end
        rst = 1'b0;
        clear_in();
        step();
    endtask

    task automatic test_load_use();
        exe_mem_read = 1'b1; exe_wb_en = 1'b1; exe_dest = 4'd3; id_src1 = 4'd3;
        #1;
        tests++;
        if (ctl_a !== STALL || ctl_b !== STALL) begin
            fails++; $display("FAIL load_use_stall: a=%b b=%b expected %b", ctl_a, ctl_b, STALL);
        end
        step();
        clear_in();
        #1;
        tests++;
        if (ctl_a !== IDLE || ctl_b !== IDLE) begin
            fails++; $display("FAIL load_use_release: a=%b b=%b expected %b", ctl_a, ctl_b, IDLE);
        end
        tests++;
        if (a_stall !== 16'd1 || b_stall !== 16'd1) begin
            fails++; $display("FAIL load_use_cnt: a=%0d b=%0d expected 1", a_stall, b_stall);
        end
    endtask

    task automatic test_forwarding();
        exe_wb_en = 1'b1; exe_mem_read = 1'b0; exe_dest = 4'd5; id_src2 = 4'd5; id_two_src = 1'b1;
        #1;
        tests++;
        if (ctl_a !== IDLE || ctl_b !== STALL) begin
            fails++; $display("FAIL fwd_exe: a=%b b=%b expected %b/%b", ctl_a, ctl_b, IDLE, STALL);
        end
        step();
        clear_in();
        mem_wb_en = 1'b1; mem_dest = 4'd7; id_src1 = 4'd7;
        #1;
        tests++;
        if (ctl_a !== IDLE || ctl_b !== STALL) begin
            fails++; $display("FAIL fwd_mem: a=%b b=%b expected %b/%b", ctl_a, ctl_b, IDLE, STALL);
        end
        step();
        clear_in();
        // src2 matches but is not a real operand
        exe_wb_en = 1'b1; exe_mem_read = 1'b1; exe_dest = 4'd9; id_src1 = 4'd1; id_src2 = 4'd9;
        #1;
        tests++;
        if (ctl_a !== IDLE || ctl_b !== IDLE) begin
            fails++; $display("FAIL one_src: a=%b b=%b expected %b", ctl_a, ctl_b, IDLE);
        end
        step();
        clear_in();
        #1;
        tests++;
        if (a_stall !== 16'd1 || b_stall !== 16'd3) begin
            fails++; $display("FAIL fwd_cnt: a=%0d b=%0d expected 1/3", a_stall, b_stall);
        end
    endtask

    task automatic test_branch();
        logic [4:0] exp_a [4];
        logic [4:0] exp_b [4];
        exp_a = '{FLUSH, FLUSH, IDLE, IDLE};
        exp_b = '{FLUSH, FLUSH, FLUSH, IDLE};
        for (int i = 0; i < 4; i++) begin
            clear_in();
            if (i == 0) br_taken = 1'b1;
            // second cycle: wrong-path branch and a load-use hazard, both must be ignored
            if (i == 1) begin
                br_taken = 1'b1; exe_wb_en = 1'b1; exe_mem_read = 1'b1; exe_dest = 4'd2; id_src1 = 4'd2;
            end
            #1;
            tests++;
            if (ctl_a !== exp_a[i] || ctl_b !== exp_b[i]) begin
                fails++; $display("FAIL branch_c%0d: a=%b b=%b expected %b/%b", i, ctl_a, ctl_b, exp_a[i], exp_b[i]);
            end
            step();
        end
        clear_in();
        tests++;
        if (a_flush !== 16'd1 || b_flush !== 16'd1 || a_stall !== 16'd1 || b_stall !== 16'd3) begin
            fails++; $display("FAIL branch_cnt: a=%0d/%0d b=%0d/%0d expected flush 1 stall 1/3", a_flush, a_stall, b_flush, b_stall);
        end
    endtask

    task automatic test_mem_hold_branch();
        logic [4:0] exp_a [7];
        logic [4:0] exp_b [7];
        exp_a = '{HOLD, HOLD, HOLD, FLUSH, FLUSH, IDLE, IDLE};
        exp_b = '{HOLD, HOLD, HOLD, FLUSH, FLUSH, FLUSH, IDLE};
        for (int i = 0; i < 7; i++) begin
            clear_in();
            mem_busy = (i < 3);
            br_taken = (i == 0);
            #1;
            tests++;
            if (ctl_a !== exp_a[i] || ctl_b !== exp_b[i]) begin
                fails++; $display("FAIL mem_br_c%0d: a=%b b=%b expected %b/%b", i, ctl_a, ctl_b, exp_a[i], exp_b[i]);
            end
            step();
        end
        clear_in();
        tests++;
        if (a_flush !== 16'd2 || b_flush !== 16'd2 || a_stall !== 16'd4 || b_stall !== 16'd6) begin
            fails++; $display("FAIL mem_br_cnt: a=%0d/%0d b=%0d/%0d expected flush 2 stall 4/6", a_flush, a_stall, b_flush, b_stall);
        end
    endtask

    task automatic test_flush_hold();
        logic [4:0] exp_a [5];
        logic [4:0] exp_b [5];
        exp_a = '{FLUSH, HOLD, FLUSH, IDLE, IDLE};
        exp_b = '{FLUSH, HOLD, FLUSH, FLUSH, IDLE};
        for (int i = 0; i < 5; i++) begin
            clear_in();
            br_taken = (i == 0);
            mem_busy = (i == 1);
            #1;
            tests++;
            if (ctl_a !== exp_a[i] || ctl_b !== exp_b[i]) begin
                fails++; $display("FAIL flush_hold_c%0d: a=%b b=%b expected %b/%b", i, ctl_a, ctl_b, exp_a[i], exp_b[i]);
            end
            step();
        end
        clear_in();
        tests++;
        if (a_flush !== 16'd3 || b_flush !== 16'd3 || a_stall !== 16'd5 || b_stall !== 16'd7) begin
            fails++; $display("FAIL flush_hold_cnt: a=%0d/%0d b=%0d/%0d expected flush 3 stall 5/7", a_flush, a_stall, b_flush, b_stall);
        end
    endtask

    task automatic test_saturation_reset();
        clear_in();
        mem_busy = 1'b1;
        for (int i = 0; i < 70000; i++) step();
        mem_busy = 1'b0;
        #1;
        tests++;
        if (a_stall !== 16'hFFFF || b_stall !== 16'hFFFF) begin
            fails++; $display("FAIL stall_sat: a=%h b=%h expected ffff", a_stall, b_stall);
        end
        br_taken = 1'b1;
        step();
        br_taken = 1'b0;
        rst = 1'b1;
        #1;
        tests++;
        if (ctl_a !== IDLE || ctl_b !== IDLE) begin
            fails++; $display("FAIL rst_in_flush_ctl: a=%b b=%b expected %b", ctl_a, ctl_b, IDLE);
        end
        step();
        rst = 1'b0;
        #1;
        tests++;
        if (ctl_a !== IDLE || ctl_b !== IDLE || a_stall !== 16'd0 || a_flush !== 16'd0
            || b_stall !== 16'd0 || b_flush !== 16'd0) begin
            fails++; $display("FAIL rst_after_flush: a=%b %0d/%0d b=%b %0d/%0d expected idle 0/0",
                              ctl_a, a_stall, a_flush, ctl_b, b_stall, b_flush);
        end
        step();
        // reset during a memory hold with a branch pending must drop the branch
        mem_busy = 1'b1; br_taken = 1'b1;
        step();
        br_taken = 1'b0; rst = 1'b1;
        step();
        rst = 1'b0; mem_busy = 1'b0;
        #1;
        tests++;
        if (ctl_a !== IDLE || ctl_b !== IDLE) begin
            fails++; $display("FAIL rst_in_hold: a=%b b=%b expected %b", ctl_a, ctl_b, IDLE);
        end
        step();
        tests++;
        if (a_flush !== 16'd0 || b_flush !== 16'd0) begin
            fails++; $display("FAIL rst_no_pend: a=%0d b=%0d expected 0", a_flush, b_flush);
        end
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_forwarding();
        test_branch();
        test_mem_hold_branch();
        test_flush_hold();
        test_saturation_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
